// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline stage: default payload width,
// zero word used for reset clears, and the bundled stage-control signals.
package pipe_pkg;

    localparam int DATA_W_DEFAULT = 32;

    localparam logic [DATA_W_DEFAULT-1:0] ZERO_WORD = '0;

    typedef struct packed {
        logic stall;
        logic flush;
        logic wfi;
        logic irq_pulse;
    } stage_ctrl_t;

endpackage

// File: rtl/pipe_slot.sv
// One payload entry: a DATA_W register with load enable and async active-low clear.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_i,
    input  logic [DATA_W-1:0] d_i,
    output logic [DATA_W-1:0] q_o
);

    logic [DATA_W-1:0] data_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q <= DATA_W'(ZERO_WORD);
        end else if (ld_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic valid/ready pipeline stage (1 = register stage, 2 = skid stage) with
// hazard stall, flush, and WFI freeze that an interrupt pulse can override.
module pipe_stage_elastic
    import pipe_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEFAULT,
    parameter int DEPTH       = 2,
    parameter bit HOLD_ON_WFI = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    input  logic              stall,
    input  logic              flush,
    input  logic              wfi,
    input  logic              irq_pulse,
    output logic [1:0]        occupancy
);

    if (DEPTH != 1 && DEPTH != 2) begin : g_bad_depth
        $error("pipe_stage_elastic: DEPTH must be 1 or 2");
    end

    localparam logic [1:0] DEPTH_L = 2'(DEPTH);

    stage_ctrl_t                  ctrl;
    logic                         freeze, push, pop, rdy_q;
    logic [1:0]                   occ_q, occ_d, wr_idx;
    logic [DEPTH-1:0]             slot_ld;
    logic [DEPTH-1:0][DATA_W-1:0] slot_d, slot_q;

    assign ctrl   = {stall, flush, wfi, irq_pulse};
    assign freeze = ctrl.stall | (HOLD_ON_WFI & ctrl.wfi & ~ctrl.irq_pulse);

    // rdy_q keeps in_ready low through reset and for the first edge after it.
    if (DEPTH == 1) begin : g_rdy_reg
        assign in_ready = rdy_q & ~freeze & ~ctrl.flush & ((occ_q == 2'd0) | out_ready);
    end else begin : g_rdy_skid
        assign in_ready = rdy_q & ~freeze & ~ctrl.flush & (occ_q < DEPTH_L);
    end

    assign out_valid = (occ_q != 2'd0) & ~freeze;
    assign out_data  = slot_q[0];
    assign occupancy = occ_q;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    // Entries shift toward slot 0 on pop, so a push lands just above the survivors.
    assign wr_idx    = occ_q - {1'b0, pop};

    always_comb begin
        occ_d = occ_q;
        if (ctrl.flush) begin
            occ_d = 2'd0;
        end else if (push & ~pop) begin
            occ_d = occ_q + 2'd1;
        end else if (pop & ~push) begin
            occ_d = occ_q - 2'd1;
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        localparam logic [1:0] IDX = 2'(i);
        logic wr_here;
        assign wr_here = push & (wr_idx == IDX);
        if (i == DEPTH - 1) begin : g_tail
            assign slot_ld[i] = ~ctrl.flush & wr_here;
            assign slot_d[i]  = in_data;
        end else begin : g_body
            assign slot_ld[i] = ~ctrl.flush & (wr_here | (pop & (occ_q > IDX + 2'd1)));
            assign slot_d[i]  = wr_here ? in_data : slot_q[i+1];
        end
        pipe_slot #(.DATA_W(DATA_W)) u_slot (
            .clk  (clk),
            .rst  (rst),
            .ld_i (slot_ld[i]),
            .d_i  (slot_d[i]),
            .q_o  (slot_q[i])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occ_q <= 2'd0;
            rdy_q <= 1'b0;
        end else begin
            occ_q <= occ_d;
            rdy_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: DEPTH=1 and DEPTH=2 instances share stimulus and
// are checked every cycle against queue models, plus directed literal checks.
module tb_pipe_stage_elastic;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid, out_ready, stall, flush, wfi, irq_pulse;
    logic [31:0] in_data;
    logic [1:0]  ir, ov;
    logic [31:0] od [2];
    logic [1:0]  oc [2];

    int nchk = 0;
    int nerr = 0;
    bit en = 1'b0;

    always #5 clk = ~clk;

    pipe_stage_elastic #(.DATA_W(32), .DEPTH(1), .HOLD_ON_WFI(1'b1)) u_d1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(ir[0]),
        .out_valid(ov[0]), .out_data(od[0]), .out_ready(out_ready), .stall(stall),
        .flush(flush), .wfi(wfi), .irq_pulse(irq_pulse), .occupancy(oc[0]));

    pipe_stage_elastic #(.DATA_W(32), .DEPTH(2), .HOLD_ON_WFI(1'b1)) u_d2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(ir[1]),
        .out_valid(ov[1]), .out_data(od[1]), .out_ready(out_ready), .stall(stall),
        .flush(flush), .wfi(wfi), .irq_pulse(irq_pulse), .occupancy(oc[1]));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Behavioural model: one FIFO queue per depth, index 0 = DEPTH 1.
    logic [31:0] mq [2][$];
    bit          rdy_m = 1'b0;
    bit          frz, e_ir, e_ov;
    int          dep;

    always @(negedge clk) begin
        if (en) begin
            if (!rst) begin
                for (int k = 0; k < 2; k++) begin
                    chk($sformatf("m%0d_rst_out_valid", k + 1), 32'(ov[k]), 32'd0);
                    chk($sformatf("m%0d_rst_out_data", k + 1), od[k], 32'd0);
                    chk($sformatf("m%0d_rst_occ", k + 1), 32'(oc[k]), 32'd0);
                    chk($sformatf("m%0d_rst_in_ready", k + 1), 32'(ir[k]), 32'd0);
                    mq[k].delete();
                end
                rdy_m = 1'b0;
            end else begin
                frz = stall | (wfi & ~irq_pulse);
                for (int k = 0; k < 2; k++) begin
                    dep  = k + 1;
                    e_ir = rdy_m && !frz && !flush &&
                           (mq[k].size() < dep || (dep == 1 && out_ready));
                    e_ov = (mq[k].size() != 0) && !frz;
                    chk($sformatf("m%0d_in_ready", dep), 32'(ir[k]), 32'(e_ir));
                    chk($sformatf("m%0d_out_valid", dep), 32'(ov[k]), 32'(e_ov));
                    chk($sformatf("m%0d_occ", dep), 32'(oc[k]), 32'(mq[k].size()));
                    if (e_ov) chk($sformatf("m%0d_out_data", dep), od[k], mq[k][0]);
                    if (flush) begin
                        mq[k].delete();
                    end else begin
                        if (e_ov && out_ready) void'(mq[k].pop_front());
                        if (in_valid && e_ir) mq[k].push_back(in_data);
                    end
                end
                rdy_m = 1'b1;
            end
        end
    end

    initial begin
        in_valid = 1'b1; in_data = 32'hDEADBEEF; out_ready = 1'b0;
        stall = 1'b0; flush = 1'b0; wfi = 1'b0; irq_pulse = 1'b0;
        repeat (2) cyc();
        en = 1'b1;

        // reset
        @(negedge clk);
        chk("rst_out_valid", 32'(ov[1]), 32'd0);
        chk("rst_out_data", od[1], 32'd0);
        chk("rst_occ", 32'(oc[1]), 32'd0);
        cyc(); rst = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        chk("rdy_before_first_edge", 32'(ir[1]), 32'd0);
        cyc();
        @(negedge clk);
        chk("rdy_after_first_edge_d2", 32'(ir[1]), 32'd1);
        chk("rdy_after_first_edge_d1", 32'(ir[0]), 32'd1);

        // streaming, both depths
        cyc(); out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h1;
        cyc(); in_data = 32'h2;
        @(negedge clk);
        chk("str_d2_data1", od[1], 32'h1); chk("str_d2_occ1", 32'(oc[1]), 32'd1);
        chk("str_d1_data1", od[0], 32'h1); chk("str_d1_ready", 32'(ir[0]), 32'd1);
        cyc(); in_data = 32'h3;
        @(negedge clk);
        chk("str_d2_data2", od[1], 32'h2); chk("str_d1_data2", od[0], 32'h2);
        cyc(); in_valid = 1'b0;
        @(negedge clk);
        chk("str_d2_data3", od[1], 32'h3); chk("str_d2_occ3", 32'(oc[1]), 32'd1);
        cyc();
        @(negedge clk);
        chk("str_drained", 32'(oc[1]), 32'd0);

        // backpressure
        cyc(); out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA;
        cyc(); in_data = 32'hB;
        @(negedge clk);
        chk("bp_d1_ready_full", 32'(ir[0]), 32'd0);
        chk("bp_d2_ready_one", 32'(ir[1]), 32'd1);
        cyc(); in_data = 32'hC;
        @(negedge clk);
        chk("bp_d2_ready_full", 32'(ir[1]), 32'd0);
        chk("bp_d2_occ2", 32'(oc[1]), 32'd2);
        chk("bp_model_size", 32'(mq[1].size()), 32'd2);
        cyc(); in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("bp_first_out", od[1], 32'hA); chk("bp_first_valid", 32'(ov[1]), 32'd1);
        cyc();
        @(negedge clk);
        chk("bp_second_out", od[1], 32'hB); chk("bp_second_occ", 32'(oc[1]), 32'd1);
        cyc();
        @(negedge clk);
        chk("bp_c_rejected", 32'(oc[1]), 32'd0);

        // WFI freeze and interrupt wake
        cyc(); out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h55;
        cyc(); in_valid = 1'b0; wfi = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("wfi_out_valid", 32'(ov[1]), 32'd0);
            chk("wfi_in_ready", 32'(ir[1]), 32'd0);
            chk("wfi_data_held", od[1], 32'h55);
            chk("wfi_occ_held", 32'(oc[1]), 32'd1);
            cyc();
        end
        irq_pulse = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        chk("wake_out_valid", 32'(ov[1]), 32'd1);
        chk("wake_out_data", od[1], 32'h55);
        cyc(); irq_pulse = 1'b0; wfi = 1'b0;
        @(negedge clk);
        chk("wake_popped", 32'(oc[1]), 32'd0);

        // flush beats push and stall
        cyc(); out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h10;
        cyc(); in_data = 32'h20;
        cyc(); in_data = 32'h30; flush = 1'b1; stall = 1'b1;
        @(negedge clk);
        chk("fl_occ_before", 32'(oc[1]), 32'd2);
        chk("fl_in_ready", 32'(ir[1]), 32'd0);
        cyc(); flush = 1'b0; stall = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("fl_d2_occ", 32'(oc[1]), 32'd0); chk("fl_d1_occ", 32'(oc[0]), 32'd0);
        chk("fl_out_valid", 32'(ov[1]), 32'd0);

        // reset mid-transfer
        cyc(); in_valid = 1'b1; in_data = 32'h77;
        cyc(); in_valid = 1'b0; rst = 1'b0;
        @(negedge clk);
        chk("mrst_out_valid", 32'(ov[1]), 32'd0);
        chk("mrst_occ", 32'(oc[1]), 32'd0);
        cyc(); rst = 1'b1;

        // randomized traffic, checked by the model every cycle
        repeat (3000) begin
            cyc();
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            stall     = ($urandom_range(0, 9) == 0);
            flush     = ($urandom_range(0, 15) == 0);
            wfi       = ($urandom_range(0, 7) == 0);
            irq_pulse = ($urandom_range(0, 3) == 0);
        end
        cyc();
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
